// File: rtl/alu_rr_arbiter_if.sv
// Request/result bundle between the issuing clients and the shared ADD/XOR ALU arbiter.
// master drives requests and consumes results; slave is the arbiter side.
interface alu_rr_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned WIDTH   = 16
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_sel;
  logic                     res_valid;
  logic                     res_ready;
  logic [WIDTH-1:0]         res_data;
  logic [ID_W-1:0]          res_id;
  logic                     busy;

  modport master (
    output req_valid, req_a, req_b, req_sel, res_ready,
    input  req_ready, res_valid, res_data, res_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, res_ready,
    output req_ready, res_valid, res_data, res_id, busy
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ADD/XOR ALU between NUM_REQ requesters.
// One operation per grant: IDLE (accept) -> EXEC (compute) -> HOLD (result until taken).
module alu_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned WIDTH   = 16
) (
  input  logic            clk,
  input  logic            rst,
  alu_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StExec, StHold} state_e;

  state_e           state_q;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [ID_W-1:0]  id_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sel_q;
  logic [WIDTH-1:0] res_data_q;
  logic [ID_W-1:0]  res_id_q;
  logic             res_valid_q;

  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] b_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = bus.req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = bus.req_b[i*WIDTH +: WIDTH];
  end

  // Search starts just past the last winner, so it has lowest priority next round.
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!grant_found && bus.req_valid[ID_W'((32'(rr_ptr_q) + k) % NUM_REQ)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  // Gated by rst so no transfer is advertised on an edge that reset will discard.
  always_comb begin
    bus.req_ready = '0;
    if (!rst && state_q == StIdle && grant_found) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  logic [WIDTH-1:0] alu_res;
  assign alu_res = sel_q ? (a_q ^ b_q) : (a_q + b_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      res_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_found) begin
            a_q      <= a_arr[grant_idx];
            b_q      <= b_arr[grant_idx];
            sel_q    <= bus.req_sel[grant_idx];
            id_q     <= grant_idx;
            rr_ptr_q <= grant_idx;
            state_q  <= StExec;
          end
        end
        StExec: begin
          res_data_q  <= alu_res;
          res_id_q    <= id_q;
          res_valid_q <= 1'b1;
          state_q     <= StHold;
        end
        StHold: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: inputs change just after negedge, outputs sampled #1 later.
module tb_alu_rr_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned WIDTH   = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  alu_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .WIDTH(WIDTH)) bus ();

  alu_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int i, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic sel);
    bus.req_valid[i]             = v;
    bus.req_a[i*WIDTH +: WIDTH]  = a;
    bus.req_b[i*WIDTH +: WIDTH]  = b;
    bus.req_sel[i]               = sel;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '1;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_sel = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin failures++;
      $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
    checks++; if (bus.res_valid !== 1'b0) begin failures++;
      $display("FAIL reset_res_valid got=%b exp=0", bus.res_valid); end
    checks++; if (bus.res_data !== 16'h0000) begin failures++;
      $display("FAIL reset_res_data got=%h exp=0000", bus.res_data); end
    checks++; if (bus.res_id !== 2'd0) begin failures++;
      $display("FAIL reset_res_id got=%0d exp=0", bus.res_id); end
    checks++; if (bus.busy !== 1'b0) begin failures++;
      $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++;
      $display("FAIL reset_idle_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_single_add();
    @(negedge clk);
    set_req(0, 1'b1, 16'h1234, 16'h1111, 1'b0);
    bus.res_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin failures++;
      $display("FAIL add_grant got=%b exp=0001", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    checks++; if (bus.busy !== 1'b1 || bus.res_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL add_exec busy=%b res_valid=%b req_ready=%b exp busy=1 res_valid=0 ready=0000",
               bus.busy, bus.res_valid, bus.req_ready); end
    @(negedge clk);
    #1;
    checks++; if (bus.res_valid !== 1'b1) begin failures++;
      $display("FAIL add_res_valid got=%b exp=1", bus.res_valid); end
    checks++; if (bus.res_data !== 16'h2345) begin failures++;
      $display("FAIL add_res_data got=%h exp=2345", bus.res_data); end
    checks++; if (bus.res_id !== 2'd0) begin failures++;
      $display("FAIL add_res_id got=%0d exp=0", bus.res_id); end
    @(negedge clk);
    #1;
    checks++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.res_data !== 16'h2345) begin
      failures++;
      $display("FAIL add_done res_valid=%b busy=%b data=%h exp 0 0 2345",
               bus.res_valid, bus.busy, bus.res_data); end
  endtask

  task automatic test_wrap_xor();
    @(negedge clk);
    set_req(2, 1'b1, 16'hFFFF, 16'h0002, 1'b0);
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin failures++;
      $display("FAIL wrap_grant got=%b exp=0100", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    #1;
    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h0001 || bus.res_id !== 2'd2) begin
      failures++;
      $display("FAIL wrap_result valid=%b data=%h id=%0d exp 1 0001 2",
               bus.res_valid, bus.res_data, bus.res_id); end
    @(negedge clk);
    set_req(2, 1'b1, 16'hA5A5, 16'h0F0F, 1'b1);
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin failures++;
      $display("FAIL xor_grant got=%b exp=0100", bus.req_ready); end
    @(negedge clk);
    set_req(2, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    #1;
    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 16'hAAAA || bus.res_id !== 2'd2) begin
      failures++;
      $display("FAIL xor_result valid=%b data=%h id=%0d exp 1 aaaa 2",
               bus.res_valid, bus.res_data, bus.res_id); end
  endtask

  task automatic test_fairness();
    @(negedge clk);
    set_req(1, 1'b1, 16'h0010, 16'h0001, 1'b0);
    set_req(3, 1'b1, 16'h00F0, 16'h000F, 1'b1);
    #1;
    checks++; if (bus.req_ready !== 4'b1000) begin failures++;
      $display("FAIL fair_first_grant got=%b exp=1000", bus.req_ready); end
    @(negedge clk);
    bus.req_valid[3] = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin failures++;
      $display("FAIL fair_exec_ready got=%b exp=0000", bus.req_ready); end
    @(negedge clk);
    #1;
    checks++; if (bus.res_id !== 2'd3 || bus.res_data !== 16'h00FF) begin failures++;
      $display("FAIL fair_res3 id=%0d data=%h exp 3 00ff", bus.res_id, bus.res_data); end
    @(negedge clk);
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin failures++;
      $display("FAIL fair_second_grant got=%b exp=0010", bus.req_ready); end
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (bus.res_id !== 2'd1 || bus.res_data !== 16'h0011) begin failures++;
      $display("FAIL fair_res1 id=%0d data=%h exp 1 0011", bus.res_id, bus.res_data); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    set_req(0, 1'b1, 16'h0003, 16'h0004, 1'b0);
    bus.res_ready = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin failures++;
      $display("FAIL bp_grant got=%b exp=0001", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '1;
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin failures++;
      $display("FAIL bp_exec_ready got=%b exp=0000", bus.req_ready); end
    @(negedge clk);
    #1;
    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h0007 || bus.res_id !== 2'd0) begin
      failures++;
      $display("FAIL bp_result valid=%b data=%h id=%0d exp 1 0007 0",
               bus.res_valid, bus.res_data, bus.res_id); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h0007 || bus.res_id !== 2'd0 ||
          bus.busy !== 1'b1 || bus.req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d valid=%b data=%h id=%0d busy=%b ready=%b exp 1 0007 0 1 0000",
                 c, bus.res_valid, bus.res_data, bus.res_id, bus.busy, bus.req_ready);
      end
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++;
      $display("FAIL bp_release valid=%b busy=%b exp 0 0", bus.res_valid, bus.busy); end
    checks++; if (bus.req_ready !== 4'b0010) begin failures++;
      $display("FAIL bp_next_grant got=%b exp=0010", bus.req_ready); end
    bus.req_valid = '0;
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    set_req(1, 1'b1, 16'h0101, 16'h0202, 1'b0);
    bus.res_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin failures++;
      $display("FAIL rmo_grant got=%b exp=0010", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b1) begin failures++;
      $display("FAIL rmo_exec_busy got=%b exp=1", bus.busy); end
    @(negedge clk);
    #1;
    checks++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.res_data !== 16'h0000 ||
                  bus.res_id !== 2'd0) begin
      failures++;
      $display("FAIL rmo_reset valid=%b busy=%b data=%h id=%0d exp 0 0 0000 0",
               bus.res_valid, bus.busy, bus.res_data, bus.res_id); end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++; if (bus.res_valid !== 1'b0) begin failures++;
        $display("FAIL rmo_no_result cyc=%0d got=%b exp=0", c, bus.res_valid); end
    end
    set_req(0, 1'b1, 16'h0001, 16'h0001, 1'b0);
    set_req(1, 1'b1, 16'h0001, 16'h0001, 1'b0);
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin failures++;
      $display("FAIL rmo_first_grant got=%b exp=0001", bus.req_ready); end
    bus.req_valid = '0;
  endtask

  task automatic test_contention();
    int          g_idx [5];
    int          g_cyc [5];
    int          r_id  [5];
    logic [15:0] r_dat [5];
    int          r_cyc [5];
    int          ng = 0;
    int          nr = 0;
    int          viol = 0;
    logic [15:0] exp_dat [5];
    exp_dat = '{16'h1001, 16'h2002, 16'h3003, 16'h4004, 16'h1001};
    for (int k = 0; k < 5; k++) begin
      g_idx[k] = -1; g_cyc[k] = -1; r_id[k] = -1; r_dat[k] = 'x; r_cyc[k] = -1;
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(i, 1'b1, 16'((i + 1) * 4096), 16'(i + 1), (i % 2) == 1);
    end
    bus.res_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      #1;
      if (!$onehot0(bus.req_ready) || (bus.req_ready & ~bus.req_valid) != 4'b0000) viol++;
      if (bus.req_ready != 4'b0000 && ng < 5) begin
        for (int b = 0; b < 4; b++) if (bus.req_ready[b]) g_idx[ng] = b;
        g_cyc[ng] = cyc;
        ng++;
      end
      if (bus.res_valid === 1'b1 && nr < 5) begin
        r_id[nr]  = int'(bus.res_id);
        r_dat[nr] = bus.res_data;
        r_cyc[nr] = cyc;
        nr++;
      end
      @(negedge clk);
    end
    bus.req_valid = '0;
    checks++; if (viol != 0) begin failures++;
      $display("FAIL cont_ready_rules violations=%0d exp=0", viol); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (g_idx[k] != k % 4 || g_cyc[k] != 3 * k) begin failures++;
        $display("FAIL cont_grant k=%0d idx=%0d cyc=%0d exp idx=%0d cyc=%0d",
                 k, g_idx[k], g_cyc[k], k % 4, 3 * k); end
      checks++; if (r_id[k] != k % 4 || r_dat[k] !== exp_dat[k] || r_cyc[k] != 3 * k + 2) begin
        failures++;
        $display("FAIL cont_result k=%0d id=%0d data=%h cyc=%0d exp id=%0d data=%h cyc=%0d",
                 k, r_id[k], r_dat[k], r_cyc[k], k % 4, exp_dat[k], 3 * k + 2); end
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_wrap_xor();
    test_fairness();
    test_backpressure();
    test_reset_mid_op();
    test_contention();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
